// File: rtl/fxy_sweep.sv
// fxy_sweep: steps an N-input vector through all 2^N values and streams
// f/g truth-table outputs, counting and locating f/g disagreements.
module fxy_sweep #(
    parameter int N = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [(1<<N)-1:0]  f_tab,
    input  logic [(1<<N)-1:0]  g_tab,
    output logic               busy,
    output logic [N-1:0]       vec,
    output logic               s1,
    output logic               s2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N:0]         mism_cnt,
    output logic [N-1:0]       first_mism,
    output logic               done,
    output logic               equal
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [(1<<N)-1:0] f_lat;
    logic [(1<<N)-1:0] g_lat;
    logic              xfer;
    logic              last;

    // Function values follow the registered vector and the frozen tables
    always_comb begin
        s1        = f_lat[vec];
        s2        = g_lat[vec];
        busy      = (state == S_RUN);
        out_valid = (state == S_RUN);
        done      = (state == S_DONE);
        equal     = (state == S_DONE) && (mism_cnt == '0);
        xfer      = (state == S_RUN) && out_ready;
        last      = &vec;
    end

    // Sweep control: table capture, vector stepping, mismatch bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            f_lat      <= '0;
            g_lat      <= '0;
            vec        <= '0;
            mism_cnt   <= '0;
            first_mism <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        f_lat      <= f_tab;
                        g_lat      <= g_tab;
                        vec        <= '0;
                        mism_cnt   <= '0;
                        first_mism <= '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (s1 != s2) begin
                            mism_cnt <= mism_cnt + 1'b1;
                            if (mism_cnt == '0) begin
                                first_mism <= vec;
                            end
                        end
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            vec <= vec + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
